// File: rtl/automat_monitor.sv
// automat_monitor: runs a reference model of a 4-state Mealy automaton in
// lock-step with an observed implementation. It compares the observed
// {m,n} with the expected {m,n} every enabled cycle and reports:
// - err:     a one-cycle pulse after each mismatch
// - err_cnt: a saturating mismatch count
// - fail:    a sticky failure flag
// - stuck:   an indication that the automaton is parked in S1
module automat_monitor #(
    parameter int CNT_W     = 8,
    parameter int STUCK_LIM = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    input  logic             m,
    input  logic             n,
    output logic [3:0]       st,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail,
    output logic             stuck
);

    localparam int                 RUN_W   = $clog2(STUCK_LIM + 1);
    localparam logic [RUN_W-1:0]   RUN_MAX = RUN_W'(STUCK_LIM);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    typedef enum logic [3:0] {
        S0 = 4'b0001,
        S1 = 4'b0010,
        S2 = 4'b0100,
        S3 = 4'b1000
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       exp_mn;
    logic             mismatch;
    logic             err_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             fail_reg, fail_next;
    logic [RUN_W-1:0] run_reg, run_next;

    // Reference transition/output table.
    // Any non-one-hot encoding falls into the S0 row, so a corrupted state
    // recovers to a legal code on the next enabled edge.
    always_comb begin
        state_next = state_reg;
        exp_mn     = 2'b00;
        case (state_reg)
            S1: begin
                state_next = S1;
                exp_mn     = 2'b00;
            end
            S2: begin
                if (a) begin
                    state_next = S1;
                    exp_mn     = 2'b10;
                end else begin
                    state_next = S2;
                    exp_mn     = 2'b01;
                end
            end
            S3: begin
                state_next = S2;
                exp_mn     = 2'b11;
            end
            default: begin
                case ({a, b})
                    2'b11:   begin state_next = S1; exp_mn = 2'b10; end
                    2'b01:   begin state_next = S2; exp_mn = 2'b00; end
                    2'b10:   begin state_next = S0; exp_mn = 2'b01; end
                    default: begin state_next = S3; exp_mn = 2'b00; end
                endcase
            end
        endcase
        // The tracked state advances only on qualified samples.
        // It never resynchronises to the observed machine.
        if (!en) begin
            state_next = state_reg;
        end
    end

    assign mismatch = en & ({m, n} != exp_mn);

    // Error count, sticky flag and S1 run length.
    // clr wins over a same-cycle mismatch; the err pulse is unaffected by clr.
    always_comb begin
        cnt_next  = cnt_reg;
        fail_next = fail_reg;
        run_next  = run_reg;
        if (clr) begin
            cnt_next  = '0;
            fail_next = 1'b0;
            run_next  = '0;
        end else if (en) begin
            if (mismatch) begin
                if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
                fail_next = 1'b1;
            end
            if (state_reg == S1) begin
                if (run_reg != RUN_MAX) begin
                    run_next = run_reg + RUN_W'(1);
                end
            end else begin
                run_next = '0;
            end
        end
    end

    // State and status registers; rst clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            fail_reg  <= 1'b0;
            run_reg   <= '0;
        end else begin
            state_reg <= state_next;
            err_reg   <= mismatch;
            cnt_reg   <= cnt_next;
            fail_reg  <= fail_next;
            run_reg   <= run_next;
        end
    end

    assign st      = state_reg;
    assign err     = err_reg;
    assign err_cnt = cnt_reg;
    assign fail    = fail_reg;
    assign stuck   = (run_reg == RUN_MAX);

endmodule

// File: tb/tb_automat_monitor.sv
// tb_automat_monitor: directed plus random checks of automat_monitor.
// The DUT is built with CNT_W=2 so that err_cnt saturation is reachable.
// An independent model pushes expectations into a scoreboard queue; each
// expectation is popped after the clock edge and compared with the DUT.
module tb_automat_monitor;

    logic       clk = 1'b0;
    logic       rst, en, clr, a, b, m, n;
    logic [3:0] st;
    logic       err;
    logic [1:0] err_cnt;
    logic       fail, stuck;

    int errors = 0;
    int checks = 0;

    // Model state: ms is the state index 0..3.
    int ms, mcnt, mrun;
    bit merr, mfail;

    typedef struct {
        logic [3:0] st;
        logic       err;
        logic [1:0] cnt;
        logic       fail;
        logic       stuck;
    } exp_t;

    exp_t sb[$];

    automat_monitor #(.CNT_W(2), .STUCK_LIM(16)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .a(a), .b(b), .m(m), .n(n),
        .st(st), .err(err), .err_cnt(err_cnt), .fail(fail), .stuck(stuck)
    );

    always #5 clk = ~clk;

    // Safety net in case the run never reaches its summary.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference automaton, written from the transition table by state index.
    function automatic void ref_fn(input int s, input bit ai, input bit bi,
                                   output int nx, output logic [1:0] mn);
        if (s == 1) begin
            nx = 1; mn = 2'b00;
        end else if (s == 2) begin
            nx = ai ? 1 : 2;
            mn = ai ? 2'b10 : 2'b01;
        end else if (s == 3) begin
            nx = 2; mn = 2'b11;
        end else if (ai && bi) begin
            nx = 1; mn = 2'b10;
        end else if (!ai && bi) begin
            nx = 2; mn = 2'b00;
        end else if (ai) begin
            nx = 0; mn = 2'b01;
        end else begin
            nx = 3; mn = 2'b00;
        end
    endfunction

    function automatic exp_t model_now();
        exp_t x;
        x.st    = 4'(1 << ms);
        x.err   = merr;
        x.cnt   = 2'(mcnt);
        x.fail  = mfail;
        x.stuck = (mrun == 16);
        return x;
    endfunction

    task automatic model_reset();
        ms = 0; mcnt = 0; mrun = 0; merr = 0; mfail = 0;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end else begin
            x = sb.pop_front();
            $display("txn %s: st=%b err=%b cnt=%0d fail=%b stuck=%b (exp st=%b err=%b cnt=%0d fail=%b stuck=%b)",
                     tag, st, err, err_cnt, fail, stuck, x.st, x.err, x.cnt, x.fail, x.stuck);
            check({tag, "_st"},    st,            x.st);
            check({tag, "_err"},   {3'b0, err},   {3'b0, x.err});
            check({tag, "_cnt"},   {2'b0, err_cnt}, {2'b0, x.cnt});
            check({tag, "_fail"},  {3'b0, fail},  {3'b0, x.fail});
            check({tag, "_stuck"}, {3'b0, stuck}, {3'b0, x.stuck});
        end
    endtask

    // One sampled cycle: drive at negedge, predict, compare after posedge.
    // When bad is set, the observed {m,n} is the bitwise inverse of the
    // expected value, which guarantees a mismatch.
    task automatic step(input string tag, input bit e, input bit c,
                        input bit ai, input bit bi, input bit bad);
        int         nx;
        logic [1:0] mn;
        @(negedge clk);
        ref_fn(ms, ai, bi, nx, mn);
        en = e; clr = c; a = ai; b = bi;
        {m, n} = bad ? ~mn : mn;
        merr = e && bad;
        if (c) begin
            mcnt = 0; mfail = 0; mrun = 0;
        end else if (e) begin
            if (bad) begin
                if (mcnt < 3) mcnt++;
                mfail = 1;
            end
            if (ms == 1) mrun = (mrun < 16) ? mrun + 1 : 16;
            else         mrun = 0;
        end
        if (e) ms = nx;
        sb.push_back(model_now());
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    // Asynchronous reset check, taken between clock edges.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        #1;
        model_reset();
        sb.push_back(model_now());
        compare(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0; m = 1'b0; n = 1'b0;
        model_reset();

        // Reset is visible before any clock edge.
        #1;
        sb.push_back(model_now());
        compare("rst_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sb.push_back(model_now());
        compare("rst_release");

        // S0 -> S3 -> S2 with correct outputs.
        step("s0_to_s3", 1, 0, 0, 0, 0);
        step("s3_to_s2", 1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

        // Stay in S2 for three cycles, then move to S1.
        for (int i = 0; i < 3; i++) step("s2_hold", 1, 0, 0, 0, 0);
        step("s2_to_s1", 1, 0, 1, 0, 0);

        // Park in S1 until stuck rises.
        for (int i = 0; i < 16; i++) step("s1_run", 1, 0, 1'(i), 1'(i >> 1), 0);
        // Disabled cycles hold everything, even with a mismatch present.
        for (int i = 0; i < 4; i++) step("en_off", 0, 0, 1'(i), 1, i == 2);
        async_reset("rst_stuck");

        // Mismatch from S0 gives a single err pulse.
        step("bad_s0", 1, 0, 1, 1, 1);
        step("after_bad", 1, 0, 0, 0, 0);

        // Counter saturation, then clear.
        step("clr0", 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("sat", 1, 0, 1'(i), 0, 1);
        step("clr1", 1, 1, 0, 0, 0);

        // Mid-sequence asynchronous reset, then a mismatch coincident with clr.
        step("pre_rst", 1, 0, 1, 1, 1);
        async_reset("rst_mid");
        step("clr_bad", 1, 1, 0, 0, 1);

        // Random mix.
        for (int i = 0; i < 60; i++)
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
